// File: rtl/calc_pkg.sv
// Shared widths, loader state encoding and field-check masks for the calculator issue path.
package calc_pkg;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_OP,
    S_A,
    S_B,
    S_EXEC,
    S_RES
  } state_t;

  // Bits that must be zero in a well-formed op word and operand word respectively.
  localparam logic [WORD_W-1:0] OP_HI_MASK   = ~WORD_W'((1 << OP_W) - 1);
  localparam logic [WORD_W-1:0] DATA_HI_MASK = ~WORD_W'((1 << DATA_W) - 1);

endpackage

// File: rtl/calc_operand_loader.sv
// Collects op/A/B words from a serial stream, drives the external ALU and
// returns its captured result over a valid/ready port, counting completions.
module calc_operand_loader
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              fmt_err,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state;
  state_t            state_nxt;
  logic              in_hs;
  logic              res_hs;
  logic [WORD_W-1:0] hi_mask;

  // Next-state decode; clr overrides any handshake in flight.
  always_comb begin
    state_nxt = state;
    hi_mask   = DATA_HI_MASK;
    in_hs     = in_valid && in_ready;
    res_hs    = res_valid && res_ready;
    case (state)
      S_OP: begin
        hi_mask = OP_HI_MASK;
        if (in_hs) state_nxt = S_A;
      end
      S_A:     if (in_hs) state_nxt = S_B;
      S_B:     if (in_hs) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RES;
      S_RES:   if (res_hs) state_nxt = S_OP;
      default: state_nxt = S_OP;
    endcase
    if (clr) state_nxt = S_OP;
  end

  // in_ready is registered from the next state, so it depends on state alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OP;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_OP) || (state_nxt == S_A) || (state_nxt == S_B);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      fmt_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      fmt_err <= 1'b0;
      if (in_hs && !clr) begin
        fmt_err <= |(in_data & hi_mask);
        case (state)
          S_OP:    alu_op <= in_data[OP_W-1:0];
          S_A:     alu_a  <= in_data[DATA_W-1:0];
          S_B:     alu_b  <= in_data[DATA_W-1:0];
          default: ;
        endcase
      end

      if (state == S_EXEC && !clr) begin
        res_data  <= alu_out;
        res_valid <= 1'b1;
      end else if (clr || res_hs) begin
        res_valid <= 1'b0;
      end

      if (res_hs && !clr) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_calc_operand_loader.sv
// Directed bench for calc_operand_loader with an XOR stub standing in for the ALU.
module tb_calc_operand_loader;
  import calc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              fmt_err;
  logic [CNT_W-1:0]  op_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign alu_out = alu_a ^ alu_b;

  calc_operand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .fmt_err   (fmt_err),
    .op_count  (op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 10'd3; res_ready = 1'b1;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
    checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    checks++; if (fmt_err !== 1'b0) begin failures++; $display("FAIL reset_fmt_err: got %0b want 0", fmt_err); end
    checks++; if ({alu_op, alu_a, alu_b, res_data} !== 14'd0) begin failures++; $display("FAIL reset_datapath: got %0h want 0", {alu_op, alu_a, alu_b, res_data}); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    send_word(10'b10);
    send_word(10'd5);
    send_word(10'd3);
    checks++; if (alu_op !== 2'b10) begin failures++; $display("FAIL basic_op: got %0d want 2", alu_op); end
    checks++; if (alu_a !== 4'd5) begin failures++; $display("FAIL basic_a: got %0d want 5", alu_a); end
    checks++; if (alu_b !== 4'd3) begin failures++; $display("FAIL basic_b: got %0d want 3", alu_b); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_exec_in_ready: got %0b want 0", in_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_exec_res_valid: got %0b want 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_res_valid: got %0b want 1", res_valid); end
    checks++; if (res_data !== 4'd6) begin failures++; $display("FAIL basic_res_data: got %0d want 6", res_data); end
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_res_drop: got %0b want 0", res_valid); end
    checks++; if (op_count !== 8'd1) begin failures++; $display("FAIL basic_count: got %0d want 1", op_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_again: got %0b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    send_word(10'b10);
    send_word(10'd5);
    send_word(10'd3);
    tick();
    in_valid = 1'b1;
    in_data  = 10'd1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 4'd6) begin failures++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0d want v=1 d=6", i, res_valid, res_data); end
      checks++; if (in_ready !== 1'b0 || alu_a !== 4'd5) begin failures++; $display("FAIL bp_ignore[%0d]: got rdy=%0b a=%0d want rdy=0 a=5", i, in_ready, alu_a); end
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got %0b want 0", res_valid); end
    checks++; if (op_count !== 8'd2) begin failures++; $display("FAIL bp_count: got %0d want 2", op_count); end
  endtask

  task automatic test_truncation();
    res_ready = 1'b1;
    send_word(10'h006);
    checks++; if (alu_op !== 2'd2 || fmt_err !== 1'b1) begin failures++; $display("FAIL trunc_op: got op=%0d err=%0b want op=2 err=1", alu_op, fmt_err); end
    send_word(10'h3F5);
    checks++; if (alu_a !== 4'd5 || fmt_err !== 1'b1) begin failures++; $display("FAIL trunc_a: got a=%0d err=%0b want a=5 err=1", alu_a, fmt_err); end
    send_word(10'd2);
    checks++; if (alu_b !== 4'd2 || fmt_err !== 1'b0) begin failures++; $display("FAIL trunc_b: got b=%0d err=%0b want b=2 err=0", alu_b, fmt_err); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 4'd7 || fmt_err !== 1'b0) begin failures++; $display("FAIL trunc_result: got v=%0b d=%0d err=%0b want v=1 d=7 err=0", res_valid, res_data, fmt_err); end
    tick();
    checks++; if (op_count !== 8'd3) begin failures++; $display("FAIL trunc_count: got %0d want 3", op_count); end
  endtask

  task automatic test_clr_mid_triple();
    res_ready = 1'b1;
    send_word(10'd1);
    send_word(10'd7);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'd8;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || alu_b !== 4'd2 || alu_a !== 4'd7) begin failures++; $display("FAIL clr_word_dropped: got rdy=%0b a=%0d b=%0d want rdy=1 a=7 b=2", in_ready, alu_a, alu_b); end
    send_word(10'd0);
    send_word(10'd9);
    send_word(10'd9);
    checks++; if (alu_op !== 2'd0 || alu_a !== 4'd9 || alu_b !== 4'd9) begin failures++; $display("FAIL clr_next_triple: got op=%0d a=%0d b=%0d want 0/9/9", alu_op, alu_a, alu_b); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 4'd0) begin failures++; $display("FAIL clr_result: got v=%0b d=%0d want v=1 d=0", res_valid, res_data); end
    tick();
    checks++; if (op_count !== 8'd4) begin failures++; $display("FAIL clr_count: got %0d want 4", op_count); end
  endtask

  task automatic test_clr_in_res();
    res_ready = 1'b0;
    send_word(10'd1);
    send_word(10'd2);
    send_word(10'd3);
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 4'd1) begin failures++; $display("FAIL clrres_pending: got v=%0b d=%0d want v=1 d=1", res_valid, res_data); end
    clr       = 1'b1;
    res_ready = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL clrres_drop: got v=%0b rdy=%0b want v=0 rdy=1", res_valid, in_ready); end
    checks++; if (op_count !== 8'd4 || res_data !== 4'd1) begin failures++; $display("FAIL clrres_keep: got cnt=%0d d=%0d want cnt=4 d=1", op_count, res_data); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    res_ready = 1'b1;
    for (int i = 0; i < 252; i++) begin
      a = DATA_W'(i);
      b = DATA_W'(i * 7);
      send_word(WORD_W'(i % 4));
      send_word(WORD_W'(a));
      send_word(WORD_W'(b));
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== (a ^ b)) begin failures++; $display("FAIL b2b_result[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, res_valid, res_data, a ^ b); end
      tick();
      if (i == 250) begin
        checks++; if (op_count !== 8'd255) begin failures++; $display("FAIL wrap_pre: got %0d want 255", op_count); end
      end
    end
    checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL wrap: got %0d want 0", op_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_truncation();
    test_clr_mid_triple();
    test_clr_in_res();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
